// File: rtl/vga_arb_pkg.sv
// Shared types and default sizing for the VGA frame-buffer arbiter.
// Optional grant statistics are enabled with the VGA_ARB_STATS_EN macro.
package vga_arb_pkg;

  localparam int ADDR_W_DEF        = 19;
  localparam int DATA_W_DEF        = 16;
  localparam int MAX_OUT_DEF       = 4;
  localparam int HOST_MAX_WAIT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_DISP = 2'd1,
    OWN_HOST = 2'd2
  } arb_state_t;

  // Identifies a requester, both as a read-return tag and as the last grantee.
  typedef enum logic {
    TAG_DISP = 1'b0,
    TAG_HOST = 1'b1
  } tag_t;

endpackage

// File: rtl/vga_tag_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding read.
// The caller guarantees no push when full (unless popping) and no pop when empty.
module vga_tag_fifo
  import vga_arb_pkg::*;
#(
  parameter  int DEPTH = MAX_OUT_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             vga_CLK,
  input  logic             rst,
  input  logic             push,
  input  tag_t             push_tag,
  input  logic             pop,
  output tag_t             head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  tag_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array has no reset; only pointers and count need a
  // defined value, and leaving the array unreset lets it map onto plain flops/RAM.
  always_ff @(posedge vga_CLK) begin
    if (push) mem[wr_ptr] <= push_tag;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge vga_CLK) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates one single-port frame-buffer interface between the display fetcher
// and a host port; define VGA_ARB_STATS_EN to add grant counters.
module vga_fb_arbiter
  import vga_arb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MAX_OUT       = MAX_OUT_DEF,
  parameter int HOST_MAX_WAIT = HOST_MAX_WAIT_DEF
) (
  input  logic              vga_CLK,
  input  logic              rst,
  input  logic              blank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              err
`ifdef VGA_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [31:0]       disp_grants,
  output logic [31:0]       host_grants
`endif
);

  localparam int CNT_W  = $clog2(MAX_OUT + 1);
  localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);

  arb_state_t        state;
  arb_state_t        state_nxt;
  tag_t              last;
  logic [WAIT_W-1:0] host_wait;
  logic              grant_valid;
  logic              grant_host;

  logic              fifo_push;
  logic              fifo_pop;
  tag_t              fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] rdata_q;

  logic rd_room;
  logic disp_elig;
  logic host_elig;
  logic host_forced;

  assign rd_room     = (fifo_count < CNT_W'(MAX_OUT));
  assign disp_elig   = disp_req && rd_room;
  assign host_elig   = host_req && (host_we || rd_room);
  assign host_forced = (host_wait >= WAIT_W'(HOST_MAX_WAIT));

  always_ff @(posedge vga_CLK) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    grant_valid = 1'b0;
    grant_host  = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    disp_ack    = 1'b0;
    host_ack    = 1'b0;
    unique case (state)
      IDLE: begin
        if (blank) begin
          // Active video: display first unless the host has waited too long.
          if (host_elig && (host_forced || !disp_elig)) begin
            grant_valid = 1'b1;
            grant_host  = 1'b1;
          end else if (disp_elig) begin
            grant_valid = 1'b1;
          end
        end else if (disp_elig && host_elig) begin
          grant_valid = 1'b1;
          grant_host  = (last == TAG_DISP);
        end else if (disp_elig || host_elig) begin
          grant_valid = 1'b1;
          grant_host  = host_elig;
        end
        if (grant_valid) state_nxt = grant_host ? OWN_HOST : OWN_DISP;
      end
      OWN_DISP: begin
        mem_req  = 1'b1;
        mem_addr = disp_addr;
        disp_ack = mem_ack;
        if (mem_ack) state_nxt = IDLE;
      end
      OWN_HOST: begin
        mem_req   = 1'b1;
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        host_ack  = mem_ack;
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge vga_CLK) begin
    if (rst) begin
      last      <= TAG_DISP;
      host_wait <= '0;
    end else begin
      if (grant_valid) last <= grant_host ? TAG_HOST : TAG_DISP;
      if (host_ack)
        host_wait <= '0;
      else if (host_req && (state != OWN_HOST) && (host_wait != '1))
        host_wait <= host_wait + 1'b1;
    end
  end

  assign fifo_push = mem_req && mem_ack && !mem_we && (!fifo_full || fifo_pop);
  assign fifo_pop  = mem_rvalid && !fifo_empty;

  vga_tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .vga_CLK  (vga_CLK),
    .rst      (rst),
    .push     (fifo_push),
    .push_tag ((state == OWN_HOST) ? TAG_HOST : TAG_DISP),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Returns with no outstanding tag are dropped and flagged until reset.
  always_ff @(posedge vga_CLK) begin
    if (rst) begin
      rdata_q     <= '0;
      disp_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      err         <= 1'b0;
    end else begin
      disp_rvalid <= fifo_pop && (fifo_head == TAG_DISP);
      host_rvalid <= fifo_pop && (fifo_head == TAG_HOST);
      if (fifo_pop) rdata_q <= mem_rdata;
      if (mem_rvalid && fifo_empty) err <= 1'b1;
    end
  end

  assign disp_rdata = rdata_q;
  assign host_rdata = rdata_q;

`ifdef VGA_ARB_STATS_EN
  always_ff @(posedge vga_CLK) begin
    if (rst || stats_clr) begin
      disp_grants <= '0;
      host_grants <= '0;
    end else begin
      if (disp_ack && (disp_grants != '1)) disp_grants <= disp_grants + 32'd1;
      if (host_ack && (host_grants != '1)) host_grants <= host_grants + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: the main process queues stimulus and
// expected grants/returns, an independent monitor checks acks and read returns.
module tb_vga_fb_arbiter;
  import vga_arb_pkg::*;

  localparam int ADDR_W        = 19;
  localparam int DATA_W        = 16;
  localparam int MAX_OUT       = 4;
  localparam int HOST_MAX_WAIT = 64;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } host_txn_t;

  typedef struct packed {
    tag_t              tag;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  logic              vga_CLK;
  logic              rst;
  logic              blank;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ack;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              err;

  int vectors     = 0;
  int miscompares = 0;

  logic [ADDR_W-1:0] disp_q[$];
  host_txn_t         host_q[$];
  logic [DATA_W-1:0] ret_q[$];
  tag_t              exp_grant_q[$];
  rd_exp_t           exp_rd_q[$];

  logic auto_ack   = 1'b0;
  logic auto_ret   = 1'b0;
  logic host_acked = 1'b0;

  vga_fb_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .MAX_OUT       (MAX_OUT),
    .HOST_MAX_WAIT (HOST_MAX_WAIT)
  ) dut (
    .vga_CLK     (vga_CLK),
    .rst         (rst),
    .blank       (blank),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_ack    (disp_ack),
    .disp_rdata  (disp_rdata),
    .disp_rvalid (disp_rvalid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .err         (err)
  );

  initial vga_CLK = 1'b0;
  always #5 vga_CLK = ~vga_CLK;

  // Requesters must hold their request until accepted.
  a_disp_hold: assert property (@(posedge vga_CLK) disable iff (rst)
    (disp_req && !disp_ack) |=> disp_req);
  a_host_hold: assert property (@(posedge vga_CLK) disable iff (rst)
    (host_req && !host_ack) |=> host_req);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_model(input logic [ADDR_W-1:0] a);
    return a[DATA_W-1:0] ^ 16'h5A5A;
  endfunction

  function automatic rd_exp_t mk_rd(input tag_t t, input logic [DATA_W-1:0] d);
    rd_exp_t e;
    e.tag  = t;
    e.data = d;
    return e;
  endfunction

  function automatic host_txn_t mk_host(input logic we, input logic [ADDR_W-1:0] a,
                                        input logic [DATA_W-1:0] d);
    host_txn_t h;
    h.we    = we;
    h.addr  = a;
    h.wdata = d;
    return h;
  endfunction

  // Drive requester inputs from the heads of the stimulus queues.
  task automatic apply();
    disp_req  = (disp_q.size() > 0);
    disp_addr = disp_req ? disp_q[0] : '0;
    host_req  = (host_q.size() > 0);
    if (host_req) begin
      host_we    = host_q[0].we;
      host_addr  = host_q[0].addr;
      host_wdata = host_q[0].wdata;
    end else begin
      host_we    = 1'b0;
      host_addr  = '0;
      host_wdata = '0;
    end
    mem_ack = auto_ack && mem_req;
  endtask

  // One clock: sample at negedge, update drivers 1 time unit after posedge.
  task automatic tick();
    logic              fire;
    logic              d_ack;
    logic              h_ack;
    logic [ADDR_W-1:0] a;
    @(negedge vga_CLK);
    fire  = mem_req && mem_ack && !mem_we;
    a     = mem_addr;
    d_ack = disp_ack;
    h_ack = host_ack;
    @(posedge vga_CLK);
    #1;
    if (d_ack && disp_q.size() > 0) void'(disp_q.pop_front());
    if (h_ack && host_q.size() > 0) void'(host_q.pop_front());
    if (fire && auto_ret) ret_q.push_back(mem_model(a));
    host_acked = h_ack;
    if (ret_q.size() > 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = ret_q.pop_front();
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    apply();
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((disp_q.size() + host_q.size() + ret_q.size() + exp_grant_q.size()
            + exp_rd_q.size()) != 0 && n < 400) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(disp_q.size() + host_q.size() + ret_q.size()
          + exp_grant_q.size() + exp_rd_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    auto_ack = 1'b0;
    auto_ret = 1'b0;
    disp_q.delete();
    host_q.delete();
    ret_q.delete();
    apply();
    tick();
    tick();
    rst = 1'b0;
    apply();
  endtask

  // Monitor: pops the scoreboard whenever the DUT acks or returns read data.
  initial begin
    forever begin
      @(negedge vga_CLK);
      if (disp_ack || host_ack) begin
        if (exp_grant_q.size() == 0) begin
          check("spurious_ack", 32'({disp_ack, host_ack}), 32'd0);
        end else begin
          tag_t g;
          g = exp_grant_q.pop_front();
          check("grant_owner", 32'({disp_ack, host_ack}),
                (g == TAG_HOST) ? 32'd1 : 32'd2);
        end
      end
      if (disp_rvalid || host_rvalid) begin
        if (exp_rd_q.size() == 0) begin
          check("spurious_rvalid", 32'({disp_rvalid, host_rvalid}), 32'd0);
        end else begin
          rd_exp_t e;
          e = exp_rd_q.pop_front();
          check("rvalid_route", 32'({disp_rvalid, host_rvalid}),
                (e.tag == TAG_HOST) ? 32'd1 : 32'd2);
          check("rdata", 32'((e.tag == TAG_HOST) ? host_rdata : disp_rdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    blank      = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    apply();
    do_reset();

    // Reset state
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_acks", 32'({disp_ack, host_ack}), 32'd0);
    check("rst_rvalid", 32'({disp_rvalid, host_rvalid}), 32'd0);
    check("rst_rdata", 32'(disp_rdata), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Single display read during active video
    auto_ack = 1'b1;
    blank    = 1'b1;
    disp_q.push_back(19'h00010);
    exp_grant_q.push_back(TAG_DISP);
    apply();
    check("t1_idle_no_req", 32'(mem_req), 32'd0);
    tick();
    check("t1_mem_req", 32'(mem_req), 32'd1);
    check("t1_mem_addr", 32'(mem_addr), 32'h10);
    check("t1_mem_we", 32'(mem_we), 32'd0);
    check("t1_disp_ack", 32'(disp_ack), 32'd1);
    check("t1_host_ack", 32'(host_ack), 32'd0);
    tick();
    check("t1_req_drop", 32'(mem_req), 32'd0);
    ret_q.push_back(16'hABCD);
    exp_rd_q.push_back(mk_rd(TAG_DISP, 16'hABCD));
    tick();
    check("t1_rvalid_not_yet", 32'(disp_rvalid), 32'd0);
    tick();
    check("t1_disp_rvalid", 32'(disp_rvalid), 32'd1);
    check("t1_disp_rdata", 32'(disp_rdata), 32'hABCD);
    check("t1_host_rvalid", 32'(host_rvalid), 32'd0);
    wait_idle("t1");

    // Host starvation guard: IDLE at even cycles sees host_wait = 0,2,..,64,
    // so 32 display grants precede the forced host grant.
    do_reset();
    blank    = 1'b1;
    auto_ack = 1'b1;
    auto_ret = 1'b1;
    for (int i = 0; i < 40; i++) begin
      disp_q.push_back(19'h00100 + 19'(i));
      exp_rd_q.push_back(mk_rd(TAG_DISP, mem_model(19'h00100 + 19'(i))));
    end
    for (int i = 0; i < 32; i++) exp_grant_q.push_back(TAG_DISP);
    exp_grant_q.push_back(TAG_HOST);
    for (int i = 0; i < 8; i++) exp_grant_q.push_back(TAG_DISP);
    host_q.push_back(mk_host(1'b1, 19'h04000, 16'h1234));
    host_acked = 1'b0;
    apply();
    begin
      int n = 0;
      while (!host_acked && n < 300) begin
        tick();
        n++;
      end
    end
    check("t2_host_granted", 32'(host_acked), 32'd1);
    check("t2_host_wait_clear", 32'(dut.host_wait), 32'd0);
    wait_idle("t2");

    // Blanking round-robin: a lone host write leaves last = host, then
    // contention alternates starting with the display.
    do_reset();
    blank    = 1'b0;
    auto_ack = 1'b1;
    auto_ret = 1'b1;
    host_q.push_back(mk_host(1'b1, 19'h05000, 16'h0F0F));
    exp_grant_q.push_back(TAG_HOST);
    apply();
    wait_idle("t3_prime");
    for (int i = 0; i < 4; i++) begin
      disp_q.push_back(19'h00300 + 19'(i));
      exp_rd_q.push_back(mk_rd(TAG_DISP, mem_model(19'h00300 + 19'(i))));
      host_q.push_back(mk_host(1'b1, 19'h05100 + 19'(i), 16'h7700 + 16'(i)));
      exp_grant_q.push_back(TAG_DISP);
      exp_grant_q.push_back(TAG_HOST);
    end
    apply();
    wait_idle("t3");

    // Outstanding-read limit: 4 reads fill the tag FIFO, the host write
    // still goes through, the 5th read waits for a return.
    do_reset();
    blank    = 1'b1;
    auto_ack = 1'b1;
    for (int i = 0; i < 5; i++) disp_q.push_back(19'h00200 + 19'(i));
    for (int i = 0; i < 4; i++) exp_grant_q.push_back(TAG_DISP);
    exp_grant_q.push_back(TAG_HOST);
    host_q.push_back(mk_host(1'b1, 19'h06000, 16'h5555));
    apply();
    for (int i = 0; i < 14; i++) tick();
    check("t4_grants_done", 32'(exp_grant_q.size()), 32'd0);
    check("t4_fifth_withheld", 32'(mem_req), 32'd0);
    tick();
    check("t4_still_withheld", 32'(mem_req), 32'd0);
    exp_grant_q.push_back(TAG_DISP);
    ret_q.push_back(16'h0001);
    exp_rd_q.push_back(mk_rd(TAG_DISP, 16'h0001));
    begin
      int n = 0;
      while (exp_grant_q.size() != 0 && n < 20) begin
        tick();
        n++;
      end
    end
    check("t4_fifth_granted", 32'(exp_grant_q.size()), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      ret_q.push_back(16'(i));
      exp_rd_q.push_back(mk_rd(TAG_DISP, 16'(i)));
    end
    wait_idle("t4");

    // In-order return routing across requesters
    do_reset();
    blank    = 1'b1;
    auto_ack = 1'b1;
    disp_q.push_back(19'h00020);
    exp_grant_q.push_back(TAG_DISP);
    apply();
    wait_idle("t5_d0");
    host_q.push_back(mk_host(1'b0, 19'h00021, 16'h0000));
    exp_grant_q.push_back(TAG_HOST);
    apply();
    wait_idle("t5_h");
    disp_q.push_back(19'h00022);
    exp_grant_q.push_back(TAG_DISP);
    apply();
    wait_idle("t5_d1");
    ret_q.push_back(16'h1111);
    ret_q.push_back(16'h2222);
    ret_q.push_back(16'h3333);
    exp_rd_q.push_back(mk_rd(TAG_DISP, 16'h1111));
    exp_rd_q.push_back(mk_rd(TAG_HOST, 16'h2222));
    exp_rd_q.push_back(mk_rd(TAG_DISP, 16'h3333));
    wait_idle("t5");

    // Reset while the host owns the bus with two reads outstanding
    do_reset();
    blank    = 1'b1;
    auto_ack = 1'b1;
    disp_q.push_back(19'h00030);
    disp_q.push_back(19'h00031);
    exp_grant_q.push_back(TAG_DISP);
    exp_grant_q.push_back(TAG_DISP);
    apply();
    wait_idle("t6_reads");
    auto_ack = 1'b0;
    host_q.push_back(mk_host(1'b1, 19'h003FF, 16'hBEEF));
    apply();
    tick();
    check("t6_own_host_req", 32'(mem_req), 32'd1);
    check("t6_own_host_we", 32'(mem_we), 32'd1);
    check("t6_own_host_wdata", 32'(mem_wdata), 32'hBEEF);
    rst = 1'b1;
    host_q.delete();
    apply();
    tick();
    check("t6_req_dropped", 32'(mem_req), 32'd0);
    rst = 1'b0;
    apply();
    check("t6_err_clear", 32'(err), 32'd0);
    ret_q.push_back(16'hDEAD);
    ret_q.push_back(16'hBEEF);
    tick();
    tick();
    tick();
    check("t6_err_set", 32'(err), 32'd1);
    check("t6_no_rvalid", 32'({disp_rvalid, host_rvalid}), 32'd0);

    check("end_grants_left", 32'(exp_grant_q.size()), 32'd0);
    check("end_reads_left", 32'(exp_rd_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
